loop_uhat_sparse_quot_fix: RTL and testbench

LOOP_UHAT_SPARSE_QUOT_FIX -- requirements
Module: loop_uhat_sparse_quot_fix

---
 rtl/loop_uhat_sparse_pkg.sv | 19 +
 rtl/loop_uhat_sparse_delay_line.sv | 50 +++++
 rtl/loop_uhat_sparse_quot_fix.sv | 177 +++++++++++++++++
 tb/tb_loop_uhat_sparse_quot_fix.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_uhat_sparse_pkg.sv
// Shared constants for the reciprocal-multiply divider fix-up path.
// The default widths, SHIFT and MUL_LAT are the single source of truth for
// both the upstream multiplier instantiation and loop_uhat_sparse_quot_fix.
// corr_e names the three possible one-step quotient corrections.
package loop_uhat_sparse_pkg;

    localparam int X_WIDTH_DEF = 73;                        // dividend / multiplier din0
    localparam int D_WIDTH_DEF = 6;                         // divisor / multiplier din1
    localparam int P_WIDTH_DEF = X_WIDTH_DEF + D_WIDTH_DEF; // multiplier dout
    localparam int SHIFT_DEF   = 6;                         // product -> quotient shift
    localparam int MUL_LAT_DEF = 4;                         // multiplier latency (ce cycles)

    typedef enum logic [1:0] {
        CORR_KEEP = 2'd0,
        CORR_DEC  = 2'd1,
        CORR_INC  = 2'd2
    } corr_e;

endpackage

// File: rtl/loop_uhat_sparse_delay_line.sv
// Clock-enabled alignment delay: a DEPTH-deep shift register for a data word
// plus its valid bit. Only the valid bits are reset; the data stages are
// free-running storage that is meaningless unless the matching valid is set.
//
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   ce             - clock enable; all stages hold when low
//   valid, data    - word entering the line
//   delayed_valid  - valid bit DEPTH ce-cycles later
//   delayed_data   - data word DEPTH ce-cycles later
module loop_uhat_sparse_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             delayed_valid,
    output logic [WIDTH-1:0] delayed_data
);

    logic [WIDTH-1:0] data_p [DEPTH];
    logic [DEPTH-1:0] vld_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else if (ce) begin
            vld_p[0] <= valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            data_p[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign delayed_valid = vld_p[DEPTH-1];
    assign delayed_data  = data_p[DEPTH-1];

endmodule

// File: rtl/loop_uhat_sparse_quot_fix.sv
// Quotient fix-up behind a reciprocal multiplier. The upstream multiplier
// forms prod = x * recip(d); this block aligns x/d with prod, takes
// q0 = prod >> SHIFT as a quotient estimate, forms the residual x - q0*d and
// applies a single +/-1 correction to produce q and r. err is a sticky flag
// for any valid item that a single correction step cannot repair (remainder
// still outside [0, d), d == 0, or the quotient wrapped).
//
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   ce             - global clock enable shared with the multiplier
//   in_valid, x, d - dividend/divisor, presented alongside multiplier din0/din1
//   prod           - multiplier dout, MUL_LAT ce-cycles after the matching x
//   out_valid      - q/r carry a new result (MUL_LAT+3 ce-cycles after in_valid)
//   q, r           - corrected quotient and remainder (held between results)
//   err            - sticky out-of-range flag, cleared only by reset
module loop_uhat_sparse_quot_fix
    import loop_uhat_sparse_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int P_WIDTH = P_WIDTH_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [X_WIDTH-1:0] x,
    input  logic [D_WIDTH-1:0] d,
    input  logic [P_WIDTH-1:0] prod,
    output logic               out_valid,
    output logic [X_WIDTH-1:0] q,
    output logic [D_WIDTH-1:0] r,
    output logic               err
);

    localparam int M_WIDTH = X_WIDTH + D_WIDTH;   // q0*d product width
    localparam int R_WIDTH = M_WIDTH + 1;         // signed residual width
    localparam logic [X_WIDTH:0] Q_ONE = (X_WIDTH+1)'(1);

    // Direction of the single correction step, from the residual sign and size.
    function automatic corr_e pick_corr(input logic signed [R_WIDTH-1:0] r0,
                                        input logic signed [R_WIDTH-1:0] dv);
        if (r0[R_WIDTH-1]) begin
            return CORR_DEC;
        end else if (r0 >= dv) begin
            return CORR_INC;
        end
        return CORR_KEEP;
    endfunction

    // Quotient step modulo 2^X_WIDTH. The extra top bit is the carry/borrow,
    // set exactly when q0+1 overflowed or q0-1 underflowed.
    function automatic logic [X_WIDTH:0] step_quot(input logic [X_WIDTH-1:0] q0,
                                                   input corr_e corr);
        case (corr)
            CORR_INC: return {1'b0, q0} + Q_ONE;
            CORR_DEC: return {1'b0, q0} - Q_ONE;
            default:  return {1'b0, q0};
        endcase
    endfunction

    // Matching remainder step.
    function automatic logic signed [R_WIDTH-1:0] step_rem(input logic signed [R_WIDTH-1:0] r0,
                                                           input logic signed [R_WIDTH-1:0] dv,
                                                           input corr_e corr);
        case (corr)
            CORR_INC: return r0 - dv;
            CORR_DEC: return r0 + dv;
            default:  return r0;
        endcase
    endfunction

    // ---- Alignment: x/d/valid delayed to meet prod (stage p0) ----
    logic               vld_p0;
    logic [M_WIDTH-1:0] xd_p0;
    logic [X_WIDTH-1:0] x_p0;
    logic [D_WIDTH-1:0] d_p0;

    loop_uhat_sparse_delay_line #(
        .WIDTH (M_WIDTH),
        .DEPTH (MUL_LAT)
    ) u_align (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .valid         (in_valid),
        .data          ({x, d}),
        .delayed_valid (vld_p0),
        .delayed_data  (xd_p0)
    );

    assign x_p0 = xd_p0[M_WIDTH-1:D_WIDTH];
    assign d_p0 = xd_p0[D_WIDTH-1:0];

    // ---- E1: quotient estimate from the shifted product (stage p1) ----
    logic               vld_p1;
    logic [X_WIDTH-1:0] q0_p1;
    logic [X_WIDTH-1:0] x_p1;
    logic [D_WIDTH-1:0] d_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (ce) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            q0_p1 <= X_WIDTH'(prod >> SHIFT);
            x_p1  <= x_p0;
            d_p1  <= d_p0;
        end
    end

    // ---- E2: back-multiply and signed residual (stage p2) ----
    logic               [M_WIDTH-1:0] back_p1;
    logic signed        [R_WIDTH-1:0] r0_p1;
    logic                             vld_p2;
    logic               [X_WIDTH-1:0] q0_p2;
    logic               [D_WIDTH-1:0] d_p2;
    logic signed        [R_WIDTH-1:0] r0_p2;

    assign back_p1 = M_WIDTH'(q0_p1) * M_WIDTH'(d_p1);
    assign r0_p1   = $signed({1'b0, M_WIDTH'(x_p1)}) - $signed({1'b0, back_p1});

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
        end else if (ce) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            q0_p2 <= q0_p1;
            d_p2  <= d_p1;
            r0_p2 <= r0_p1;
        end
    end

    // ---- E3: one-step correction into the output registers ----
    logic signed [R_WIDTH-1:0] d_ext_p2;
    corr_e                     corr_p2;
    logic        [X_WIDTH:0]   q_step_p2;
    logic signed [R_WIDTH-1:0] r_fix_p2;
    logic                      bad_p2;

    assign d_ext_p2  = $signed({{(R_WIDTH-D_WIDTH){1'b0}}, d_p2});
    assign corr_p2   = pick_corr(r0_p2, d_ext_p2);
    assign q_step_p2 = step_quot(q0_p2, corr_p2);
    assign r_fix_p2  = step_rem(r0_p2, d_ext_p2, corr_p2);
    // The item's q/r are still delivered when the fix is out of range.
    assign bad_p2    = r_fix_p2[R_WIDTH-1] || (r_fix_p2 >= d_ext_p2) ||
                       (d_p2 == '0) || q_step_p2[X_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            err       <= 1'b0;
        end else if (ce) begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                q   <= q_step_p2[X_WIDTH-1:0];
                r   <= r_fix_p2[D_WIDTH-1:0];
                err <= err | bad_p2;
            end
        end
    end

endmodule

// File: tb/tb_loop_uhat_sparse_quot_fix.sv
// Scoreboard bench for loop_uhat_sparse_quot_fix. The bench models the
// upstream multiplier as a ce-gated MUL_LAT-deep pipe that delivers the
// prod value chosen for each item; expected q/r/err and the ce-cycle at
// which each result must appear are queued at issue time and checked by an
// independent monitor process.
module tb_loop_uhat_sparse_quot_fix;
    import loop_uhat_sparse_pkg::*;

    localparam int XW  = X_WIDTH_DEF;
    localparam int DW  = D_WIDTH_DEF;
    localparam int PW  = P_WIDTH_DEF;
    localparam int SH  = SHIFT_DEF;
    localparam int ML  = MUL_LAT_DEF;
    localparam int LAT = ML + 3;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          ce       = 1'b0;
    logic          in_valid = 1'b0;
    logic [XW-1:0] x        = '0;
    logic [DW-1:0] d        = '0;
    logic [PW-1:0] prod;
    logic [PW-1:0] prod_in  = '0;
    logic          out_valid;
    logic [XW-1:0] q;
    logic [DW-1:0] r;
    logic          err;

    logic [PW-1:0] prod_pipe [ML];

    typedef struct {
        logic [XW-1:0] q;
        logic [DW-1:0] r;
        logic          err;
        int            due;
        int            tag;
    } exp_t;

    exp_t sb[$];

    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   cnt        = 0;
    logic ce_q       = 1'b0;
    logic rst_q      = 1'b0;
    logic sticky     = 1'b0;
    bit   final_req  = 1'b0;
    bit   final_done = 1'b0;

    logic [XW-1:0] xs [16];
    logic [DW-1:0] ds [16];
    logic [PW-1:0] ps [16];
    logic [XW-1:0] qs [16];
    logic [DW-1:0] rs [16];

    loop_uhat_sparse_quot_fix dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .x         (x),
        .d         (d),
        .prod      (prod),
        .out_valid (out_valid),
        .q         (q),
        .r         (r),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Multiplier model and ce-cycle counter.
    always @(posedge clk) begin
        ce_q  <= ce;
        rst_q <= reset;
        if (ce) begin
            cnt          <= cnt + 1;
            prod_pipe[0] <= prod_in;
            for (int i = 1; i < ML; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end
    assign prod = prod_pipe[ML-1];

    // Monitor: compares every fresh result against the head of the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                sb.delete();
                sticky = 1'b0;
            end
            if (rst_q === 1'b1) begin
                n_cmp++;
                if (out_valid !== 1'b0 || q !== '0 || r !== '0 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: got out_valid=%b q=%0h r=%0d err=%b, want all zero",
                             out_valid, q, r, err);
                end
            end else if (ce_q === 1'b1 && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got q=%0h r=%0d at ce-cycle %0d, want no result",
                             q, r, cnt);
                end else begin
                    e = sb.pop_front();
                    sticky = sticky | e.err;
                    n_cmp++;
                    if (q !== e.q || r !== e.r || err !== sticky || cnt != e.due) begin
                        n_fail++;
                        $display("FAIL item%0d: got q=%0h r=%0d err=%b cyc=%0d, want q=%0h r=%0d err=%b cyc=%0d",
                                 e.tag, q, r, err, cnt, e.q, e.r, sticky, e.due);
                    end
                end
            end
            while (sb.size() != 0 && cnt > sb[0].due) begin
                e = sb.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL item%0d_missing: got no result by ce-cycle %0d, want one at %0d",
                         e.tag, cnt, e.due);
            end
            if (final_req && !final_done) begin
                n_cmp++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: got %0d results outstanding, want 0", sb.size());
                end
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [XW-1:0] xv, input logic [DW-1:0] dv,
                         input logic [PW-1:0] pv, input logic [XW-1:0] qe,
                         input logic [DW-1:0] re, input logic ee, input int tag);
        exp_t e;
        ce       = 1'b1;
        in_valid = 1'b1;
        x        = xv;
        d        = dv;
        prod_in  = pv;
        e.q = qe; e.r = re; e.err = ee; e.due = cnt + LAT; e.tag = tag;
        sb.push_back(e);
        tick();
    endtask

    // Idle cycles carry junk data with d=0 and in_valid=0; none may count.
    task automatic idle(input int n);
        ce       = 1'b1;
        in_valid = 1'b0;
        x        = {9'h1ff, $urandom(), $urandom()};
        d        = '0;
        prod_in  = PW'($urandom());
        repeat (n) tick();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) idle(1);
        idle(1);
    endtask

    task automatic do_reset(input int n, input logic ce_val);
        ce       = ce_val;
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (n) tick();
        reset    = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [XW-1:0] ones;
        logic [XW-1:0] qt;
        logic [XW-1:0] rt;
        int            off;

        // Directed-table construction: quotient estimates within +/-1.
        for (int i = 0; i < 16; i++) begin
            xs[i] = {9'(i * 37 + 5), $urandom(), $urandom()};
            ds[i] = DW'((i * 13) % 63 + 1);
            qt    = xs[i] / XW'(ds[i]);
            rt    = xs[i] % XW'(ds[i]);
            qs[i] = qt;
            rs[i] = DW'(rt);
            off   = (i % 3) - 1;
            ps[i] = (PW'(qt + XW'(off)) << SH) | PW'(i);
        end
        ones = '1;

        // Reset with ce low still clears the outputs.
        tick();
        do_reset(3, 1'b0);
        idle(2);

        // x=1000, d=7, prod=9000: q0=140, r0=20 needs two steps, one allowed.
        issue(73'd1000, 6'd7, 79'd9000, 73'd141, 6'd13, 1'b1, 1);
        wait_drain();
        do_reset(2, 1'b1);
        idle(1);

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) issue(xs[i], ds[i], ps[i], qs[i], rs[i], 1'b0, 100 + i);
        wait_drain();

        // Same stream with ce toggling; junk presented while ce is low.
        for (int i = 0; i < 16; i++) begin
            ce       = 1'b0;
            in_valid = 1'b1;
            x        = ones;
            d        = '0;
            prod_in  = '0;
            tick();
            issue(xs[i], ds[i], ps[i], qs[i], rs[i], 1'b0, 200 + i);
        end
        wait_drain();

        // Reset three cycles after an item: that item never emerges.
        issue(xs[5], ds[5], ps[5], qs[5], rs[5], 1'b0, 300);
        idle(2);
        do_reset(1, 1'b1);
        issue(xs[6], ds[6], ps[6], qs[6], rs[6], 1'b0, 301);
        wait_drain();

        // d=0 raises err, which then sticks over clean items.
        issue(73'd10, 6'd0, PW'(5) << SH, 73'd6, 6'd10, 1'b1, 400);
        issue(xs[2], ds[2], ps[2], qs[2], rs[2], 1'b0, 401);
        issue(xs[3], ds[3], ps[3], qs[3], rs[3], 1'b0, 402);
        wait_drain();
        idle(3);
        do_reset(2, 1'b1);
        idle(1);

        // x=2^73-1, d=1, estimate low by 2; then q0+1 wrap via d=0.
        issue(ones, 6'd1, PW'(ones - XW'(2)) << SH, ones - XW'(1), 6'd1, 1'b1, 500);
        issue(73'd5, 6'd0, PW'(ones) << SH, 73'd0, 6'd5, 1'b1, 501);
        wait_drain();

        final_req = 1'b1;
        for (int k = 0; k < 5 && !final_done; k++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
